// File: rtl/match_run_onehot.sv
// Masked bus-equality run detector: one-hot run tracker, level/pulse hit flag, saturating run counter.
// Optional sticky illegal-state flag on port state_err when MATCH_RUN_ERR_EN is defined.
module match_run_onehot #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               mode,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic [WIDTH-1:0]                   care_mask,
    input  logic                               hit_cnt_clr,
    output logic                               hit,
    output logic [$clog2(RUN_LEN+1)-1:0]       run_cnt,
    output logic [CNT_W-1:0]                   hit_cnt
`ifdef MATCH_RUN_ERR_EN
    ,
    output logic                               state_err
`endif
);

    localparam int unsigned NS = RUN_LEN + 1;
    localparam int unsigned CW = $clog2(RUN_LEN + 1);
    localparam logic [NS-1:0] S0_VEC = NS'(1);

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_PULSE = 1'b1
    } mode_e;

    logic [NS-1:0]    r_state;
    logic             r_hit;
    logic [CW-1:0]    r_run_cnt;
    logic [CNT_W-1:0] r_hit_cnt;

    logic             w_match;
    logic             w_legal;
    logic             w_inc;
    logic             w_hit_next;
    logic [NS-1:0]    w_next;
    logic [CW-1:0]    w_next_idx;

    assign w_match = (((a ^ b) & care_mask) == '0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_legal = (r_state != '0) && ((r_state & (r_state - NS'(1))) == '0);
    assign w_inc   = w_legal & en & w_match & r_state[RUN_LEN-1];

    always_comb begin
        w_next = r_state;
        if (!w_legal) begin
            w_next = S0_VEC;
        end else if (en) begin
            if (!w_match) begin
                w_next = S0_VEC;
            end else if (!r_state[RUN_LEN]) begin
                w_next = {r_state[NS-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_next_idx = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (w_next[i]) begin
                w_next_idx = w_next_idx | CW'(i);
            end
        end
    end

    always_comb begin
        w_hit_next = 1'b0;
        if (w_legal && en && w_match) begin
            if (mode_e'(mode) == MODE_PULSE) begin
                w_hit_next = r_state[RUN_LEN-1];
            end else begin
                w_hit_next = w_next[RUN_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S0_VEC;
            r_hit     <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_hit     <= w_hit_next;
            r_run_cnt <= w_next_idx;
        end
    end

    // A clear coincident with a run completion keeps that completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if (hit_cnt_clr) begin
            r_hit_cnt <= w_inc ? CNT_W'(1) : '0;
        end else if (w_inc && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

`ifdef MATCH_RUN_ERR_EN
    logic r_state_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_err <= 1'b0;
        end else if (!w_legal) begin
            r_state_err <= 1'b1;
        end
    end

    assign state_err = r_state_err;
`endif

    assign hit     = r_hit;
    assign run_cnt = r_run_cnt;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_match_run_onehot.sv
// Directed self-checking bench for match_run_onehot (main instance CNT_W=16, second instance CNT_W=2).
module tb_match_run_onehot;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  care_mask;
    logic        hit_cnt_clr;

    logic        hit;
    logic [2:0]  run_cnt;
    logic [15:0] hit_cnt;
    logic        hit2;
    logic [2:0]  run_cnt2;
    logic [1:0]  hit_cnt2;
`ifdef MATCH_RUN_ERR_EN
    logic        state_err;
    logic        state_err2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_run_onehot #(.WIDTH(8), .RUN_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .care_mask(care_mask), .hit_cnt_clr(hit_cnt_clr),
        .hit(hit), .run_cnt(run_cnt), .hit_cnt(hit_cnt)
`ifdef MATCH_RUN_ERR_EN
        , .state_err(state_err)
`endif
    );

    match_run_onehot #(.WIDTH(8), .RUN_LEN(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .care_mask(care_mask), .hit_cnt_clr(hit_cnt_clr),
        .hit(hit2), .run_cnt(run_cnt2), .hit_cnt(hit_cnt2)
`ifdef MATCH_RUN_ERR_EN
        , .state_err(state_err2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_run [6];
        int pulses;
        exp_run = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

        reset = 1'b1; en = 1'b0; mode = 1'b0; a = 8'h00; b = 8'h00;
        care_mask = 8'hFF; hit_cnt_clr = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_hit", {31'd0, hit}, 32'd0);
        chk("reset_run_cnt", {29'd0, run_cnt}, 32'd0);
        chk("reset_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        chk("reset_state", {27'd0, dut.r_state}, 32'd1);
`ifdef MATCH_RUN_ERR_EN
        chk("reset_state_err", {31'd0, state_err}, 32'd0);
`endif

        // Test 1: level mode, six matching cycles
        en = 1'b1; mode = 1'b0; a = 8'h5A; b = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t1_run_cnt_e%0d", i + 1), {29'd0, run_cnt}, {29'd0, exp_run[i]});
            chk($sformatf("t1_hit_e%0d", i + 1), {31'd0, hit}, (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("t1_hit_cnt", {16'd0, hit_cnt}, 32'd1);
        chk("t1_state_s4", {27'd0, dut.r_state}, 32'h10);

        // Test 2: mismatch after three matches restarts the run
        do_reset();
        a = 8'h5A; b = 8'h5A;
        for (int e = 1; e <= 8; e++) begin
            b = (e == 4) ? 8'h5B : 8'h5A;
            tick();
            chk($sformatf("t2_run_cnt_e%0d", e), {29'd0, run_cnt},
                (e <= 3) ? e : (e == 4) ? 32'd0 : e - 4);
            chk($sformatf("t2_hit_e%0d", e), {31'd0, hit}, (e == 8) ? 32'd1 : 32'd0);
        end
        chk("t2_hit_cnt", {16'd0, hit_cnt}, 32'd1);

        // Test 3: pulse mode, one pulse per run
        do_reset();
        mode = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 15; e++) begin
            b = (e == 11) ? 8'h5B : 8'h5A;
            tick();
            if (hit) pulses++;
            chk($sformatf("t3_hit_e%0d", e), {31'd0, hit}, (e == 4 || e == 15) ? 32'd1 : 32'd0);
        end
        chk("t3_pulse_count", pulses, 32'd2);
        chk("t3_hit_cnt", {16'd0, hit_cnt}, 32'd2);
        chk("t3_run_cnt", {29'd0, run_cnt}, 32'd4);

        // Test 4: masked compare, then enable low freezes the tracker
        do_reset();
        mode = 1'b0; care_mask = 8'hF0; a = 8'h31; b = 8'h3E;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("t4_run_cnt_e%0d", e), {29'd0, run_cnt}, e);
        end
        chk("t4_hit", {31'd0, hit}, 32'd1);
        en = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("t4_dis_hit_%0d", e), {31'd0, hit}, 32'd0);
            chk($sformatf("t4_dis_run_%0d", e), {29'd0, run_cnt}, 32'd4);
            chk($sformatf("t4_dis_cnt_%0d", e), {16'd0, hit_cnt}, 32'd1);
        end
        en = 1'b1;
        tick();
        chk("t4_resume_hit", {31'd0, hit}, 32'd1);
        chk("t4_resume_cnt", {16'd0, hit_cnt}, 32'd1);
        care_mask = 8'h00; a = 8'hFF; b = 8'h00;
        tick();
        chk("t4_zero_mask_match", {29'd0, run_cnt}, 32'd4);

        // Test 5: saturation of a 2-bit counter and clear coincident with completion
        do_reset();
        care_mask = 8'hFF; a = 8'h5A;
        for (int r = 0; r < 5; r++) begin
            b = 8'h5A;
            repeat (4) tick();
            b = 8'h5B;
            tick();
        end
        chk("t5_sat_cnt2", {30'd0, hit_cnt2}, 32'd3);
        chk("t5_cnt16", {16'd0, hit_cnt}, 32'd5);
        b = 8'h5A;
        repeat (3) tick();
        hit_cnt_clr = 1'b1;
        tick();
        hit_cnt_clr = 1'b0;
        chk("t5_clr_inc_cnt2", {30'd0, hit_cnt2}, 32'd1);
        chk("t5_clr_inc_cnt16", {16'd0, hit_cnt}, 32'd1);
        b = 8'h5B;
        hit_cnt_clr = 1'b1;
        tick();
        hit_cnt_clr = 1'b0;
        chk("t5_clr_alone", {30'd0, hit_cnt2}, 32'd0);

        // Test 6: illegal state recovery, then reset mid-run
        do_reset();
        mode = 1'b0; b = 8'h5A;
        repeat (2) tick();
        force dut.r_state = 5'b00110;
        tick();
        chk("t6_illegal_hit", {31'd0, hit}, 32'd0);
        chk("t6_illegal_run", {29'd0, run_cnt}, 32'd0);
        release dut.r_state;
`ifdef MATCH_RUN_ERR_EN
        chk("t6_state_err_set", {31'd0, state_err}, 32'd1);
`endif
        b = 8'h5B;
        tick();
        chk("t6_recover_state", {27'd0, dut.r_state}, 32'd1);
        chk("t6_recover_hit", {31'd0, hit}, 32'd0);
        b = 8'h5A; mode = 1'b1;
        repeat (3) tick();
        chk("t6_prerun", {29'd0, run_cnt}, 32'd3);
`ifdef MATCH_RUN_ERR_EN
        chk("t6_state_err_sticky", {31'd0, state_err}, 32'd1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_hit", {31'd0, hit}, 32'd0);
        chk("t6_reset_run", {29'd0, run_cnt}, 32'd0);
        chk("t6_reset_state", {27'd0, dut.r_state}, 32'd1);
        chk("t6_reset_cnt", {16'd0, hit_cnt}, 32'd0);
`ifdef MATCH_RUN_ERR_EN
        chk("t6_state_err_clr", {31'd0, state_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
